// File: rtl/accel_host_loader.sv
// Host-side loader for a memory-mapped accelerator: streams operands into the
// accelerator port, writes the done flag, waits for the computation, then reads
// the results back out through a small 2-entry FIFO.
module accel_host_loader #(
  parameter int unsigned N_OPERAND = 576,
  parameter int unsigned DONE_ADDR = 576,
  parameter int unsigned N_RESULT  = 1024,
  parameter int unsigned COMP_WAIT = 48
) (
  input  logic        clka,
  input  logic        rst_ni,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [31:0] src_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        ena,
  output logic        wea,
  output logic [10:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLAG,
    WAIT,
    READ,
    DRAIN
  } state_e;

  localparam logic [10:0] LAST_OP   = 11'(N_OPERAND - 1);
  localparam logic [10:0] LAST_RES  = 11'(N_RESULT - 1);
  localparam logic [10:0] DONE_A    = 11'(DONE_ADDR);
  localparam logic [10:0] RES_BASE  = 11'(DONE_ADDR + 1);
  localparam logic [31:0] WAIT_LAST = 32'(COMP_WAIT - 1);

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] wait_q, wait_d;
  logic        inflight_q, inflight_d;
  logic        rd_issue;

  logic [31:0] mem_q [2];
  logic [31:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        push, pop;

  // Job sequencing: next state, counters and the accelerator port request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    ena        = 1'b0;
    wea        = 1'b0;
    addra      = '0;
    dina       = '0;
    src_ready  = 1'b0;
    done       = 1'b0;
    rd_issue   = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        src_ready = 1'b1;
        if (src_valid) begin
          ena   = 1'b1;
          wea   = 1'b1;
          addra = cnt_q;
          dina  = src_data;
          cnt_d = cnt_q + 11'd1;
          if (cnt_q == LAST_OP) state_d = FLAG;
        end
      end
      FLAG: begin
        ena    = 1'b1;
        wea    = 1'b1;
        addra  = DONE_A;
        dina   = 32'd1;
        wait_d = '0;
        // A zero wait skips WAIT entirely so no idle cycle is inserted.
        if (COMP_WAIT == 0) begin
          state_d = READ;
          cnt_d   = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = READ;
          cnt_d   = '0;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      READ: begin
        // Every unpopped read is either in flight or buffered, so this keeps
        // the 2-entry FIFO from ever overflowing.
        if (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) begin
          ena      = 1'b1;
          addra    = RES_BASE + cnt_q;
          rd_issue = 1'b1;
          cnt_d    = cnt_q + 11'd1;
          if (cnt_q == LAST_RES) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == 2'd0 && !inflight_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = rd_issue;
  end

  // Result FIFO: capture read data one cycle after the request.
  always_comb begin
    push      = inflight_q;
    res_valid = (count_q != 2'd0);
    res_data  = mem_q[rd_ptr_q];
    pop       = res_valid && res_ready;
    mem_d     = mem_q;
    if (push) mem_d[wr_ptr_q] = douta;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
  end

  // State and datapath registers.
  always_ff @(posedge clka or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      inflight_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      inflight_q <= inflight_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_accel_host_loader.sv
// Bench for accel_host_loader: a table of job scenarios run against a
// transaction-level model of the host/accelerator exchange.
module tb_accel_host_loader;

  localparam int unsigned N_OPERAND = 576;
  localparam int unsigned DONE_ADDR = 576;
  localparam int unsigned N_RESULT  = 1024;
  localparam int unsigned COMP_WAIT = 48;
  localparam int unsigned BUDGET    = 20000;

  logic        clka = 1'b0;
  logic        rst_ni;
  logic        start;
  logic        busy, done;
  logic        src_valid, src_ready;
  logic [31:0] src_data;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        ena, wea;
  logic [10:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  accel_host_loader #(
    .N_OPERAND(N_OPERAND),
    .DONE_ADDR(DONE_ADDR),
    .N_RESULT (N_RESULT),
    .COMP_WAIT(COMP_WAIT)
  ) dut (
    .clka     (clka),
    .rst_ni   (rst_ni),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_data (src_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .ena      (ena),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .douta    (douta)
  );

  always #5 clka = ~clka;

  typedef struct {
    int unsigned src_pct;
    int unsigned rdy_pct;
    int          stall_word;
    int unsigned stall_len;
    int          bp_at;
    int unsigned bp_len;
    bit          glitch;
    int          abort_at;
    int unsigned exp_writes;
    int unsigned exp_reads;
    int unsigned exp_results;
    int unsigned exp_done;
  } job_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {busy, done, src_ready, res_valid, ena, wea, addra, dina}, 64'd0);
  endtask

  task automatic run_job(input job_vec_t v);
    logic [31:0] words [N_OPERAND];
    int unsigned n_wr = 0, n_rd = 0, n_res = 0, n_done = 0;
    int unsigned cyc = 0, flag_cyc = 0, stall_cnt = 0, bp_cnt = 0, post = 0, avail;
    bit in_job = 1'b0, finished = 1'b0, rd_last = 1'b0, prev_hold = 1'b0;
    bit stall_done = 1'b0, bp_done = 1'b0, g1 = 1'b0, g2 = 1'b0;
    logic [10:0] rd_addr_last = '0;
    logic [31:0] prev_data = '0;
    for (int unsigned k = 0; k < N_OPERAND; k++) words[k] = $urandom;

    // accept cycle
    @(negedge clka);
    start = 1'b1; src_valid = 1'b0; res_ready = 1'b1; douta = $urandom;
    #1;
    chk("busy_before_accept", busy, 0);
    chk("src_ready_idle", src_ready, 0);
    in_job = 1'b1;

    while (!finished) begin
      @(negedge clka);
      douta = rd_last ? (32'(rd_addr_last) - 32'(DONE_ADDR + 1)) : $urandom;
      start = 1'b0;
      if (v.glitch && !g1 && n_wr == 50) begin start = 1'b1; g1 = 1'b1; end
      if (v.glitch && !g2 && n_rd == 500) begin start = 1'b1; g2 = 1'b1; end
      if (v.stall_len > 0 && !stall_done && n_wr == 32'(v.stall_word + 1)) begin
        src_valid = 1'b0;
        stall_cnt++;
        if (stall_cnt == v.stall_len) stall_done = 1'b1;
      end else begin
        src_valid = ($urandom_range(99) < v.src_pct);
      end
      src_data = (n_wr < N_OPERAND) ? words[n_wr] : $urandom;
      if (v.bp_len > 0 && !bp_done && n_res == 32'(v.bp_at)) begin
        res_ready = 1'b0;
        bp_cnt++;
        if (bp_cnt == v.bp_len) bp_done = 1'b1;
      end else begin
        res_ready = ($urandom_range(99) < v.rdy_pct);
      end

      if (v.abort_at >= 0 && n_wr == 32'(v.abort_at)) begin
        src_valid = 1'b1;
        #2 rst_ni = 1'b0;
        #1 chk_all_zero("async_reset_outputs");
        start = 1'b0;
        for (int unsigned r = 0; r < 3; r++) begin
          @(negedge clka); #1;
          chk_all_zero("held_reset_outputs");
        end
        rst_ni = 1'b1;
        finished = 1'b1;
      end else begin
        #1;
        // Words visible in the FIFO were requested two or more cycles ago.
        avail = n_rd - 32'(rd_last) - n_res;
        chk("busy", busy, in_job);
        chk("src_ready", src_ready, in_job && n_wr < N_OPERAND);
        chk("res_valid", res_valid, avail > 0);
        if (!ena) chk("idle_bus_zero", {wea, addra, dina}, 0);
        if (in_job && n_wr < N_OPERAND) chk("load_ena", ena, src_valid);
        if (ena && wea) begin
          if (n_wr < N_OPERAND) begin
            chk("wr_addr", addra, n_wr);
            chk("wr_data", dina, words[n_wr]);
          end else begin
            chk("write_count", n_wr, N_OPERAND);
            chk("flag_addr", addra, DONE_ADDR);
            chk("flag_data", dina, 1);
            flag_cyc = cyc;
          end
          n_wr++;
        end
        if (ena && !wea) begin
          chk("rd_after_flag", n_wr, N_OPERAND + 1);
          if (n_rd == 0) chk("wait_gap", cyc - flag_cyc - 1, COMP_WAIT);
          chk("rd_addr", addra, DONE_ADDR + 1 + n_rd);
          n_rd++;
          chk("outstanding_le2", (n_rd - n_res) <= 2, 1);
        end
        rd_last = ena && !wea;
        rd_addr_last = addra;
        if (prev_hold) begin
          chk("bp_valid_hold", res_valid, 1);
          chk("bp_data_hold", res_data, prev_data);
        end
        prev_hold = res_valid && !res_ready;
        prev_data = res_data;
        if (res_valid && res_ready) begin
          chk("res_data", res_data, n_res);
          n_res++;
        end
        if (done) begin
          n_done++;
          chk("done_results", n_res, N_RESULT);
          chk("done_reads", n_rd, N_RESULT);
          in_job = 1'b0;
        end
        if (!in_job) begin
          post++;
          if (post > 3) finished = 1'b1;
        end
        cyc++;
        if (cyc > BUDGET) begin
          chk("job_timeout", cyc, 0);
          finished = 1'b1;
        end
      end
    end
    start = 1'b0;
    chk("n_writes", n_wr, v.exp_writes);
    chk("n_reads", n_rd, v.exp_reads);
    chk("n_results", n_res, v.exp_results);
    chk("n_done", n_done, v.exp_done);
  endtask

  initial begin
    job_vec_t jobs [5];
    //         src  rdy  stw  stl  bpa  bpl  gl  abort  wr   rd    res   done
    jobs[0] = '{100, 100,  -1,   0,  -1,   0, 0,  -1,  577, 1024, 1024, 1};
    jobs[1] = '{100, 100, 100,  10, 300,  20, 1,  -1,  577, 1024, 1024, 1};
    jobs[2] = '{100, 100,  -1,   0,  -1,   0, 0, 300,  300,    0,    0, 0};
    jobs[3] = '{ 60,  50, 200,   7, 700,  25, 0,  -1,  577, 1024, 1024, 1};
    jobs[4] = '{ 30,  80,  -1,   0,  10,   5, 1,  -1,  577, 1024, 1024, 1};

    rst_ni = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0;
    res_ready = 1'b0; douta = '0;
    #1 chk_all_zero("reset_state");
    #12 rst_ni = 1'b1;
    @(negedge clka); #1;
    chk_all_zero("idle_after_release");

    for (int unsigned j = 0; j < 5; j++) run_job(jobs[j]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_host_loader.md
ACCEL_HOST_LOADER -- requirements
Module: accel_host_loader

Interface
REQ-001 SHALL have parameter N_OPERAND, default 576, meaning operand words written to addresses 0..N_OPERAND-1.
REQ-002 SHALL have parameter DONE_ADDR, default 576, meaning the write-done flag address.
REQ-003 SHALL have parameter N_RESULT, default 1024, meaning result words read from DONE_ADDR+1 upward.
REQ-004 SHALL have parameter COMP_WAIT, default 48, meaning idle cycles between the flag write and the first result read.
REQ-005 SHALL have port clka, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, a one-cycle request to run one job.
REQ-008 SHALL have port busy, output, 1, high from job acceptance until done.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the job completes.
REQ-010 SHALL have ports src_valid (input, 1), src_ready (output, 1) and src_data (input, 32), the operand stream.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_data (output, 32), the result stream.
REQ-012 SHALL have ports ena (output, 1), wea (output, 1), addra (output, 11) and dina (output, 32), the accelerator port request.
REQ-013 SHALL have port douta, input, 32, accelerator read data, valid exactly one cycle after a read request (ena=1, wea=0).

Function
REQ-014 SHALL implement states IDLE, LOAD, FLAG, WAIT, READ, DRAIN.
REQ-015 IDLE: start=1 SHALL move to LOAD, set busy, clear the address counter; start in any other state SHALL be ignored.
REQ-016 LOAD: src_ready=1; each cycle with src_valid=1 SHALL drive ena=1, wea=1, addra=counter, dina=src_data, then increment counter; src_valid=0 SHALL drive ena=0 with no counter change.
REQ-017 The LOAD write at counter=N_OPERAND-1 SHALL move to FLAG.
REQ-018 FLAG: one cycle with ena=1, wea=1, addra=DONE_ADDR, dina=32'h1, then WAIT with wait counter=0; src_ready=0 in every state except LOAD.
REQ-019 WAIT: ena=0 for exactly COMP_WAIT cycles, then READ with counter=0.
REQ-020 READ: a read (ena=1, wea=0, addra=DONE_ADDR+1+counter) SHALL issue only when the 2-entry result FIFO occupancy plus in-flight reads is below 2; each issued read increments counter.
REQ-021 Returned douta SHALL be pushed into the FIFO on the cycle after its request; no returned word SHALL be dropped or reordered.
REQ-022 res_valid SHALL equal FIFO non-empty, with res_data at the FIFO head; a pop occurs on res_valid and res_ready both high; a simultaneous push and pop SHALL keep occupancy unchanged.
REQ-023 After the read at counter=N_RESULT-1 SHALL move to DRAIN; DRAIN SHALL exit when the FIFO is empty and none is in flight, pulsing done for one cycle, clearing busy, and returning to IDLE.
REQ-024 At most one request per cycle; ena=0 SHALL force wea=0, addra=0, dina=0.
REQ-025 Address arithmetic SHALL be 11-bit; parameter combinations with DONE_ADDR+N_RESULT>2047 are unsupported.
REQ-026 res_ready=0 held indefinitely SHALL stall READ with at most 2 buffered words and no further reads issued.

Reset
REQ-027 rst_ni=0 SHALL immediately force state IDLE, all counters 0, FIFO empty, in-flight flag 0, and busy, done, src_ready, res_valid, ena, wea, addra, dina all 0.
REQ-028 Reset asserted mid-job SHALL abandon the job with no done pulse; the next start after release SHALL begin a fresh job at address 0.

Verification
REQ-029 Full job, src_valid and res_ready always high: 576 writes to addresses 0..575 in 576 consecutive cycles -> one write of 1 to 576 -> 48 idle cycles -> reads 577..1600 -> 1024 results in address order -> one done pulse.
REQ-030 Load stall: src_valid low for 10 cycles after word 100 -> ena=0 for those 10 cycles; word 100 is written to address 100 and no address is skipped.
REQ-031 Backpressure: res_ready low for 20 cycles mid-READ -> res_valid holds with the same res_data, at most 2 words buffered, no reads issued, all data intact after release.
REQ-032 start pulsed during LOAD and during READ -> ignored; exactly one done pulse for the job.
REQ-033 rst_ni dropped at LOAD word 300 -> all outputs 0 asynchronously; after release, start -> first write to address 0.
REQ-034 Accelerator model returns {16'd0, index} for read index k -> res_data sequence 0..1023 with no gaps or duplicates.
